even_parity_checker: RTL and testbench

Serial receive-side checker for the team's 3-input even-parity generator. It deserialises DATA_W data bits plus one trailing parity bit, LSB first, and presents the recovered word. It flags frames whose total count of ones (data plus parity) is odd. It sits at the receiving end of any serial link that carries even-parity-protected words.

---
 rtl/even_parity_pkg.sv | 15 +
 rtl/even_parity_checker_if.sv | 28 ++
 rtl/even_parity_checker_sat_counter.sv | 19 +
 rtl/even_parity_checker.sv | 95 +++++++++
 tb/tb_even_parity_checker.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/even_parity_pkg.sv
// Shared types and helpers for the serial even-parity receive checker.
// The parity helper zero-extends its argument, which leaves the parity unchanged.
package even_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  function automatic logic odd_ones(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/even_parity_checker_if.sv
// Serial bit stream in, recovered word and parity verdict out.
// err_cnt and CNT_W exist only when PARITY_ERR_CNT_EN is defined.
interface even_parity_checker_if #(
  parameter int DATA_W = 3
`ifdef PARITY_ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic              bit_in;
  logic              bit_valid;
  logic              sof;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              par_err;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0]  err_cnt;

  modport master (output bit_in, bit_valid, sof,
                  input  data_out, out_valid, par_err, err_cnt);
  modport slave  (input  bit_in, bit_valid, sof,
                  output data_out, out_valid, par_err, err_cnt);
`else
  modport master (output bit_in, bit_valid, sof,
                  input  data_out, out_valid, par_err);
  modport slave  (input  bit_in, bit_valid, sof,
                  output data_out, out_valid, par_err);
`endif
endinterface

// File: rtl/even_parity_checker_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/even_parity_checker.sv
// Deserialises DATA_W data bits plus trailing even-parity bit, LSB first; result one cycle after the parity bit.
// No backpressure: gaps on bit_valid just stall the frame. PARITY_ERR_CNT_EN adds a saturating error counter.
module even_parity_checker
  import even_parity_pkg::*;
#(
  parameter int DATA_W = 3
`ifdef PARITY_ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  even_parity_checker_if.slave bus
);

  localparam int IDX_W = $clog2(DATA_W + 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] word, word_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              perr_q, perr_nxt;
  logic              valid_q, valid_nxt;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word;
    data_nxt  = data_q;
    perr_nxt  = perr_q;
    valid_nxt = 1'b0;
    if (bus.bit_valid) begin
      // sof restarts from any state, silently dropping a partial frame
      if (bus.sof) begin
        word_nxt    = '0;
        word_nxt[0] = bus.bit_in;
        idx_nxt     = IDX_W'(1);
        state_nxt   = (DATA_W == 1) ? PARITY : DATA;
      end else begin
        case (state)
          DATA: begin
            for (int i = 1; i < DATA_W; i++) begin
              if (idx == IDX_W'(i)) word_nxt[i] = bus.bit_in;
            end
            idx_nxt = idx + IDX_W'(1);
            if (idx_nxt == IDX_W'(DATA_W)) state_nxt = PARITY;
          end
          PARITY: begin
            data_nxt  = word;
            perr_nxt  = odd_ones(64'({bus.bit_in, word}));
            valid_nxt = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      word    <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      word    <= word_nxt;
      data_q  <= data_nxt;
      perr_q  <= perr_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.par_err   = perr_q;
  assign bus.out_valid = valid_q;

`ifdef PARITY_ERR_CNT_EN
  logic err_inc;
  assign err_inc = valid_nxt & perr_nxt;

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (bus.err_cnt)
  );
`endif

endmodule

// File: tb/tb_even_parity_checker.sv
// Randomised and directed bench for even_parity_checker with a frame-level reference model.
module tb_even_parity_checker;

  localparam int DATA_W = 3;
`ifdef PARITY_ERR_CNT_EN
  localparam int CNT_W  = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef PARITY_ERR_CNT_EN
  even_parity_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  even_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  even_parity_checker_if #(.DATA_W(DATA_W)) bus ();
  even_parity_checker #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit started  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: collect bits since sof, judge when DATA_W+1 have arrived.
  logic [DATA_W:0]   m_bits = '0;
  int                m_len  = 0;
  bit                m_in_frame = 0;
  logic              m_valid = 0;
  logic [DATA_W-1:0] m_data  = '0;
  logic              m_perr  = 0;
  int                m_cnt   = 0;

  always @(posedge clk) begin
    m_valid = 0;
    if (rst) begin
      m_in_frame = 0;
      m_data = '0;
      m_perr = 0;
      m_cnt  = 0;
    end else if (bus.bit_valid) begin
      if (bus.sof) begin
        m_bits = '0;
        m_bits[0] = bus.bit_in;
        m_len = 1;
        m_in_frame = 1;
      end else if (m_in_frame) begin
        m_bits[m_len] = bus.bit_in;
        m_len++;
        if (m_len == DATA_W + 1) begin
          m_valid = 1;
          m_data  = m_bits[DATA_W-1:0];
          m_perr  = ($countones(m_bits) % 2) == 1;
          m_in_frame = 0;
`ifdef PARITY_ERR_CNT_EN
          if (m_perr && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("cmp_data_out", 32'(bus.data_out), 32'(m_data));
      chk("cmp_par_err", 32'(bus.par_err), 32'(m_perr));
`ifdef PARITY_ERR_CNT_EN
      chk("cmp_err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
`endif
      if (bus.out_valid === 1'b1) pulses++;
    end
  end

  task automatic send_bit(input logic b, input logic s);
    bus.bit_in = b;
    bus.sof = s;
    bus.bit_valid = 1'b1;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    bus.sof = 1'b0;
    bus.bit_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // bits[0] is sent first; bits[DATA_W] is the parity bit
  task automatic send_frame(input logic [DATA_W:0] bits, input int gap);
    for (int i = 0; i <= DATA_W; i++) begin
      send_bit(bits[i], i == 0);
      if (i < DATA_W) idle(gap);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int p0;
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    bus.bit_in = 0; bus.sof = 0; bus.bit_valid = 0;
    do_reset();
    started = 1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_par_err", 32'(bus.par_err), 0);
`ifdef PARITY_ERR_CNT_EN
    chk("rst_err_cnt", 32'(bus.err_cnt), 0);
`endif

    // good frame 1,1,0 parity 0
    p0 = pulses;
    send_frame(4'b0011, 0);
    chk("good_valid", 32'(bus.out_valid), 1);
    chk("good_data", 32'(bus.data_out), 32'h3);
    chk("good_perr", 32'(bus.par_err), 0);
    idle(1);
    chk("good_pulse_width", 32'(bus.out_valid), 0);
    chk("good_pulse_count", 32'(pulses - p0), 1);

    // bad frame 1,1,1 parity 0
    send_frame(4'b0111, 0);
    chk("bad_valid", 32'(bus.out_valid), 1);
    chk("bad_data", 32'(bus.data_out), 32'h7);
    chk("bad_perr", 32'(bus.par_err), 1);
`ifdef PARITY_ERR_CNT_EN
    chk("bad_err_cnt", 32'(bus.err_cnt), 1);
`endif
    idle(1);

    // good frame with two idle cycles between bits
    send_frame(4'b0011, 2);
    chk("gap_valid", 32'(bus.out_valid), 1);
    chk("gap_data", 32'(bus.data_out), 32'h3);
    chk("gap_perr", 32'(bus.par_err), 0);
    idle(1);

    // abort: 1,0 then sof 0, 0, 1, parity 1
    p0 = pulses;
    send_bit(1, 1);
    send_bit(0, 0);
    send_bit(0, 1);
    send_bit(0, 0);
    send_bit(1, 0);
    chk("abort_no_early_pulse", 32'(pulses - p0), 0);
    send_bit(1, 0);
    chk("abort_valid", 32'(bus.out_valid), 1);
    chk("abort_data", 32'(bus.data_out), 32'h4);
    chk("abort_perr", 32'(bus.par_err), 0);
    idle(1);
    chk("abort_pulse_count", 32'(pulses - p0), 1);

    // five errored frames back-to-back
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 5; k++) begin
      send_frame(4'b0111, 0);
      chk("sat_valid", 32'(bus.out_valid), 1);
`ifdef PARITY_ERR_CNT_EN
      chk("sat_err_cnt", 32'(bus.err_cnt), 32'(sat_exp[k]));
`endif
    end
    idle(1);
    chk("sat_pulse_count", 32'(pulses - p0), 5);

    // reset mid-frame discards the partial frame
    send_bit(1, 1);
    send_bit(1, 0);
    do_reset();
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_data", 32'(bus.data_out), 0);
    chk("midrst_perr", 32'(bus.par_err), 0);
`ifdef PARITY_ERR_CNT_EN
    chk("midrst_err_cnt", 32'(bus.err_cnt), 0);
`endif
    p0 = pulses;
    send_bit(0, 0);
    send_bit(1, 0);
    send_frame(4'b0011, 0);
    idle(1);
    chk("midrst_pulse_count", 32'(pulses - p0), 1);

    // random traffic, including stray bits, aborts, gaps and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.bit_valid = ($urandom_range(0, 9) < 7);
      bus.sof = bus.bit_valid && ($urandom_range(0, 7) == 0);
      bus.bit_in = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    rst = 0; bus.bit_valid = 0; bus.sof = 0; bus.bit_in = 0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
